// File: rtl/pipeline_phase_ctrl.sv
// Advance controller for the 5-stage pipeline: splits the unified memory into fetch/data slots
// and generates the pipeline-register load/flush strobes, stalls, flushes and halt drain.
module pipeline_phase_ctrl #(
  parameter int unsigned AW        = 32,
  parameter int unsigned DRAIN_ADV = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_use_hazard,
  input  logic          branch_taken,
  input  logic          halt_req,
  input  logic [AW-1:0] if_addr,
  input  logic [AW-1:0] mem_addr,
  input  logic          mem_rd,
  input  logic          mem_wr,
  output logic          phase,
  output logic [AW-1:0] mem_port_addr,
  output logic          mem_port_rd,
  output logic          mem_port_wr,
  output logic          pc_load,
  output logic          if_id_load,
  output logic          id_ex_load,
  output logic          ex_mem_load,
  output logic          mem_wb_load,
  output logic          if_id_flush,
  output logic          id_ex_flush,
  output logic          halted
);

  localparam int unsigned CW = (DRAIN_ADV < 1) ? 1 : $clog2(DRAIN_ADV + 1);

  typedef enum logic [1:0] {StRun, StDrain, StHalt} st_e;

  st_e           st_q, st_d;
  logic          phase_q, phase_d;
  logic [CW-1:0] drain_cnt_q, drain_cnt_d;
  logic          adv;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q        <= StRun;
      phase_q     <= 1'b0;
      drain_cnt_q <= '0;
    end else begin
      st_q        <= st_d;
      phase_q     <= phase_d;
      drain_cnt_q <= drain_cnt_d;
    end
  end

  // The pipeline advances on the edge that closes the data slot.
  assign adv = phase_q & (st_q != StHalt);

  always_comb begin
    st_d        = st_q;
    phase_d     = phase_q;
    drain_cnt_d = drain_cnt_q;
    pc_load     = 1'b0;
    if_id_load  = 1'b0;
    id_ex_load  = 1'b0;
    ex_mem_load = 1'b0;
    mem_wb_load = 1'b0;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;

    unique case (st_q)
      StRun: begin
        phase_d = ~phase_q;
        if (adv) begin
          if (branch_taken) begin
            pc_load     = 1'b1;
            if_id_load  = 1'b1;
            id_ex_load  = 1'b1;
            ex_mem_load = 1'b1;
            mem_wb_load = 1'b1;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
          end else if (halt_req) begin
            // PC frozen; the halting instruction proceeds while IF/ID is emptied behind it.
            if_id_load  = 1'b1;
            id_ex_load  = 1'b1;
            ex_mem_load = 1'b1;
            mem_wb_load = 1'b1;
            if_id_flush = 1'b1;
            if (DRAIN_ADV == 0) begin
              st_d = StHalt;
            end else begin
              st_d        = StDrain;
              drain_cnt_d = CW'(DRAIN_ADV);
            end
          end else if (load_use_hazard) begin
            id_ex_load  = 1'b1;
            id_ex_flush = 1'b1;
            ex_mem_load = 1'b1;
            mem_wb_load = 1'b1;
          end else begin
            pc_load     = 1'b1;
            if_id_load  = 1'b1;
            id_ex_load  = 1'b1;
            ex_mem_load = 1'b1;
            mem_wb_load = 1'b1;
          end
        end
      end

      StDrain: begin
        phase_d = ~phase_q;
        if (adv) begin
          if_id_load  = 1'b1;
          if_id_flush = 1'b1;
          id_ex_load  = 1'b1;
          ex_mem_load = 1'b1;
          mem_wb_load = 1'b1;
          drain_cnt_d = drain_cnt_q - CW'(1);
          if (drain_cnt_q == CW'(1)) begin
            st_d = StHalt;
          end
        end
      end

      StHalt: begin
        phase_d = 1'b0;
      end

      default: begin
        st_d    = StRun;
        phase_d = 1'b0;
      end
    endcase
  end

  // Fetch reads are suppressed in reset and once halted.
  always_comb begin
    if (phase_q) begin
      mem_port_addr = mem_addr;
      mem_port_rd   = mem_rd;
      mem_port_wr   = mem_wr;
    end else begin
      mem_port_addr = if_addr;
      mem_port_rd   = ~rst & (st_q != StHalt);
      mem_port_wr   = 1'b0;
    end
  end

  assign phase  = phase_q;
  assign halted = (st_q == StHalt);

endmodule

// File: tb/tb_pipeline_phase_ctrl.sv
// Scoreboard bench for pipeline_phase_ctrl: a clock-count reference model pushes expected
// outputs per cycle; a monitor on the falling edge pops and compares them.
module tb_pipeline_phase_ctrl;

  localparam int unsigned AW = 32;
  localparam int DRAIN = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          load_use_hazard, branch_taken, halt_req;
  logic [AW-1:0] if_addr, mem_addr;
  logic          mem_rd, mem_wr;
  logic          phase;
  logic [AW-1:0] mem_port_addr;
  logic          mem_port_rd, mem_port_wr;
  logic          pc_load, if_id_load, id_ex_load, ex_mem_load, mem_wb_load;
  logic          if_id_flush, id_ex_flush, halted;

  pipeline_phase_ctrl #(.AW(AW), .DRAIN_ADV(DRAIN)) dut (
    .clk             (clk),
    .rst             (rst),
    .load_use_hazard (load_use_hazard),
    .branch_taken    (branch_taken),
    .halt_req        (halt_req),
    .if_addr         (if_addr),
    .mem_addr        (mem_addr),
    .mem_rd          (mem_rd),
    .mem_wr          (mem_wr),
    .phase           (phase),
    .mem_port_addr   (mem_port_addr),
    .mem_port_rd     (mem_port_rd),
    .mem_port_wr     (mem_port_wr),
    .pc_load         (pc_load),
    .if_id_load      (if_id_load),
    .id_ex_load      (id_ex_load),
    .ex_mem_load     (ex_mem_load),
    .mem_wb_load     (mem_wb_load),
    .if_id_flush     (if_id_flush),
    .id_ex_flush     (id_ex_flush),
    .halted          (halted)
  );

  always #5 clk = ~clk;

  // {phase, addr, rd, wr, pc, ifid, idex, exmem, memwb, ifid_fl, idex_fl, halted}
  typedef logic [AW+10:0] obs_t;

  obs_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: clocks since reset, drain advances left, halted flag.
  int   m_t      = 0;
  int   m_left   = 0;
  bit   m_drain  = 0;
  bit   m_halted = 0;

  function automatic obs_t model_out();
    logic [6:0] ld;
    if (rst) return {1'b0, if_addr, 2'b00, 7'b0, 1'b0};
    if (m_halted) return {1'b0, if_addr, 2'b00, 7'b0, 1'b1};
    if (m_t % 2 == 0) return {1'b0, if_addr, 2'b10, 7'b0, 1'b0};
    // {pc, ifid, idex, exmem, memwb, ifid_fl, idex_fl}
    if (m_drain)              ld = 7'b0111110;
    else if (branch_taken)    ld = 7'b1111111;
    else if (halt_req)        ld = 7'b0111110;
    else if (load_use_hazard) ld = 7'b0011101;
    else                      ld = 7'b1111100;
    return {1'b1, mem_addr, mem_rd, mem_wr, ld, 1'b0};
  endfunction

  task automatic model_step();
    if (rst) begin
      m_t = 0; m_left = 0; m_drain = 0; m_halted = 0;
    end else if (!m_halted) begin
      if (m_t % 2 == 1) begin
        if (m_drain) begin
          m_left--;
          if (m_left == 0) begin
            m_drain  = 0;
            m_halted = 1;
          end
        end else if (!branch_taken && halt_req) begin
          m_drain = 1;
          m_left  = DRAIN;
        end
      end
      m_t++;
    end
  endtask

  // Called just after a rising edge: drive, record expectation, advance over the next edge.
  task automatic cyc(input bit r, input bit hz, input bit br, input bit hr,
                     input logic [AW-1:0] ia, input logic [AW-1:0] ma,
                     input bit rd, input bit wr);
    rst = r; load_use_hazard = hz; branch_taken = br; halt_req = hr;
    if_addr = ia; mem_addr = ma; mem_rd = rd; mem_wr = wr;
    exp_q.push_back(model_out());
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, $urandom, $urandom, 0, 0);
  endtask

  task automatic to_data_slot();
    if (m_t % 2 == 0) idle(1);
  endtask

  obs_t act;
  always_comb act = {phase, mem_port_addr, mem_port_rd, mem_port_wr, pc_load, if_id_load,
                     id_ex_load, ex_mem_load, mem_wb_load, if_id_flush, id_ex_flush, halted};

  initial begin : monitor
    obs_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (act !== e) begin
          errors++;
          $display("FAIL cycle_outputs t=%0t actual=%h required=%h", $time, act, e);
        end
      end
    end
  end

  initial begin : stim
    int guard;
    rst = 1; load_use_hazard = 0; branch_taken = 0; halt_req = 0;
    if_addr = '0; mem_addr = '0; mem_rd = 0; mem_wr = 0;
    @(posedge clk); #1;
    cyc(1, 0, 0, 0, 32'h100, 32'h200, 0, 0);
    // Free-running advances with alternating addresses.
    for (int i = 0; i < 8; i++) cyc(0, 0, 0, 0, 32'h1000 + i, 32'h2000 + i, 1, 0);
    to_data_slot();
    cyc(0, 1, 0, 0, 32'h10, 32'h20, 1, 0);
    idle(3);
    to_data_slot();
    cyc(0, 1, 1, 0, 32'h10, 32'h20, 0, 0);
    idle(2);
    cyc(0, 0, 0, 0, 32'h44, 32'h40, 0, 1);
    cyc(0, 0, 0, 0, 32'h44, 32'h40, 0, 1);
    // Halt, then reset while two drain advances remain.
    to_data_slot();
    cyc(0, 0, 0, 1, 32'h50, 32'h60, 0, 0);
    guard = 0;
    while (!(m_drain && m_left == 2) && guard < 20) begin idle(1); guard++; end
    idle(1);
    cyc(1, 0, 0, 0, 32'h70, 32'h80, 0, 0);
    idle(4);
    // Full drain into HALT; halt_req on a branch advance must be discarded.
    to_data_slot();
    cyc(0, 0, 1, 1, 32'h90, 32'ha0, 0, 0);
    idle(1);
    cyc(0, 0, 0, 1, 32'h90, 32'ha0, 0, 0);
    for (int i = 0; i < 10; i++) cyc(0, $urandom_range(1), $urandom_range(1), 1, $urandom,
                                     $urandom, $urandom_range(1), $urandom_range(1));
    cyc(1, 0, 0, 0, 32'h0, 32'h0, 0, 0);
    // Randomized traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      bit r, hz, br, hr;
      r  = ($urandom_range(99) == 0) || (m_halted && $urandom_range(7) == 0);
      br = ($urandom_range(4) == 0);
      hr = ($urandom_range(29) == 0);
      hz = hr ? 1'b0 : ($urandom_range(3) == 0);
      cyc(r, hz, br, hr, $urandom, $urandom, $urandom_range(1), $urandom_range(1));
    end
    @(negedge clk); #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain actual=%0d required=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
